uart_rx_param: RTL

- Parametrised asynchronous-serial receiver.
- Oversamples the line, majority-votes each bit, and assembles a frame into a parallel word.
- Frame format is configurable: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits.
- Reports parity and framing errors, rejects false starts, and accepts back-to-back frames with no idle gap.
- Sits between the board RX pin and the command/FIFO logic, replacing the fixed 8N1 receiver.

---
 rtl/uart_rx_param.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Oversampling asynchronous-serial receiver with configurable frame format
// (5-9 data bits, none/odd/even parity, 1-2 stop bits), parity/framing error reporting.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int M       = OVERSAMPLE / 2;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic                 rx_meta_q, rxs_q, rxs_prev_q;
    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [TW-1:0]        tidx_q, tidx_d;
    logic [1:0]           samp_q, samp_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic fall, tick, decide, bit_end, maj, exp_par;

    always_comb begin
        fall    = rxs_prev_q & ~rxs_q;
        tick    = (state_q != S_IDLE) && (div_q == DW'(DIV - 1));
        decide  = tick && (tidx_q == TW'(M + 1));
        bit_end = tick && (tidx_q == TW'(OVERSAMPLE - 1));
        // Third vote is the live sample taken on the decision tick itself
        maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
        exp_par = (PARITY == 1) ? ~(^shift_q) : ^shift_q;
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        tidx_d       = tidx_q;
        samp_d       = samp_q;
        bit_d        = bit_q;
        stop_d       = stop_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (tick) begin
            div_d  = '0;
            tidx_d = bit_end ? '0 : tidx_q + TW'(1);
        end else begin
            div_d = div_q + DW'(1);
        end
        if (tick && tidx_q == TW'(M - 1)) samp_d[0] = rxs_q;
        if (tick && tidx_q == TW'(M))     samp_d[1] = rxs_q;

        case (state_q)
            S_IDLE: begin
                div_d  = '0;
                tidx_d = '0;
                if (fall) begin
                    state_d = S_START;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (decide && maj) state_d = S_IDLE;
                else if (bit_end)  state_d = S_DATA;
            end
            S_DATA: begin
                if (decide) shift_d[bit_q] = maj;
                if (bit_end) begin
                    if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else                             bit_d   = bit_q + BW'(1);
                end
            end
            S_PARITY: begin
                if (decide && (maj != exp_par)) perr_d = 1'b1;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (decide && !maj) ferr_d = 1'b1;
                // Leave at mid-bit of the final stop bit so a following start edge is never missed
                if (decide && stop_q == 1'(STOP_BITS - 1)) begin
                    state_d      = S_IDLE;
                    rx_valid_d   = 1'b1;
                    rx_data_d    = shift_q;
                    parity_err_d = perr_q;
                    frame_err_d  = ferr_q | ~maj;
                end else if (bit_end) begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            div_q        <= '0;
            tidx_q       <= '0;
            samp_q       <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rxs_q        <= rx_meta_q;
            rxs_prev_q   <= rxs_q;
            state_q      <= state_d;
            div_q        <= div_d;
            tidx_q       <= tidx_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule
